sigmoid_rr_sched: RTL and testbench
===================================

// Module: sigmoid_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one sigmoid activation core among NREQ neuron requesters.
//  Each neuron presents a signed 8-bit pre-activation and receives a tagged 16-bit activation.
//  Output is Q8.8, where 256 = 1.0. A 2-stage pipeline gives full throughput with backpressure.
//  Sits between the neuron accumulators and the next-layer input registers of the XOR network.
// PARAMETERS
//  NREQ  4                    number of requesters (2..16)
//  IDW   $clog2(NREQ) (lp)    width of the requester tag
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       per-requester request valid
//  req_x      in   8*NREQ     signed pre-activation; requester i uses [8*i+:8]
//  req_ready  out  NREQ       one-hot accept; transfer when req_valid[i] & req_ready[i]
//  rsp_valid  out  1          result valid
//  rsp_data   out  16         signed activation, Q8.8
//  rsp_id     out  IDW        index of the requester that owns rsp_data
//  rsp_ready  in   1          downstream accept; transfer when rsp_valid & rsp_ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   s1_vld=0, s2_vld=0, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
//   Any in-flight items are dropped. Requesters must re-issue after reset.
//  Pipeline advance:
//   adv2 = rsp_ready | ~s2_vld.
//   adv1 = adv2 | ~s1_vld.
//  Arbitration (combinational):
//   Grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready = grant_onehot & {NREQ{adv1}}.
//   req_ready never asserts on an index whose req_valid is low.
//  Stage 1 (capture):
//   On accept, register x and id; set s1_vld=1.
//   On accept, rr_ptr <= (granted idx + 1) mod NREQ. rr_ptr is unchanged when nothing is accepted.
//   If adv1 and no accept, s1_vld <= 0.
//  Stage 2 (compute + register):
//   If adv2, s2 <= {s1_vld, sig(s1_x), s1_id}.
//   rsp_* are driven directly from the s2 registers.
//  Latency and stalls:
//   Accept at edge N gives rsp_valid at edge N+1 (2 registers). Throughput is 1 per cycle.
//   While rsp_valid & ~rsp_ready: rsp_data and rsp_id are held stable, and rsp_valid stays high.
//  Handshake rules:
//   A requester holds req_valid and req_x until its ready is seen.
//   req_x is sampled only on accept.
//  sig(x), all ops 8-bit signed except sq and sh:
//   y   = x[7] ? -x : x            (x=-128 wraps to -128)
//   z   = y >>> 2
//   sum = z + 8'hF0                (8-bit wrap)
//   sq  = sum*sum                  (16-bit signed)
//   sh  = sq >>> 1
//   sig = x[7] ? sh : 16'd256 - sh (16-bit wrap)
//  Fairness:
//   With all requesters continuously valid and rsp_ready=1, grants cycle 0,1,..,NREQ-1,0,...
//   Maximum wait is NREQ-1 accepts.
// STRUCTURE
//  Package nn_pkg holds:
//   XW=8, YW=16, ONE_Q88=16'd256, SIG_BIAS=8'hF0, typedef act_t (signed [15:0]).
//  Sub-module sig_pwq: combinational sig(x). Instantiated once, between s1 and s2.
//  Arbiter: rotate req_valid by rr_ptr, take a priority encode, rotate back. Inline, no sub-module.
// TESTING
//  1) Single requester 0, x=0 -> 2 cycles later rsp_data=128, rsp_id=0.
//     Then x=24 -> 206; x=-24 -> 50; x=64 -> 256; x=-64 -> 0.
//  2) All 4 requesters valid, rsp_ready=1 -> accepts in id order 0,1,2,3,0.
//     One rsp per cycle. Each rsp_data matches sig of that requester's x.
//  3) rsp_ready=0 for 5 cycles with traffic pending -> rsp held stable, exactly 2 items buffered.
//     req_ready=0 while stalled. After release, no loss or duplication and order is preserved.
//  4) Only requesters 1 and 3 valid, rr_ptr=2 -> grant 3, then 1, then 3.
//     req_ready[0] and req_ready[2] never assert.
//  5) rst_n pulled low mid-stream, asynchronously between edges -> rsp_valid and req_ready drop immediately.
//     After release, the first grant goes to the lowest valid index (rr_ptr=0).
//  6) Sweep x=-128..127 on requester 2 -> every rsp_data equals the golden sig(x) model.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nn_pkg
// Brief   : Shared widths, constants and types for the XOR-network datapath.
// Revision: 1.0 - initial release
// ============================================================================
package nn_pkg;

   localparam int          XW       = 8;
   localparam int          YW       = 16;
   localparam logic [15:0] ONE_Q88  = 16'd256;
   localparam logic [7:0]  SIG_BIAS = 8'hF0;

   typedef logic signed [YW-1:0] act_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/sig_pwq.sv
`default_nettype none
// ============================================================================
// Module  : sig_pwq
// Brief   : Combinational piecewise-quadratic sigmoid, Q8.8 output.
// Revision: 1.0 - initial release
// ============================================================================
module sig_pwq
   import nn_pkg::*;
(
   input  logic signed [XW-1:0] i_x,
   output logic signed [YW-1:0] o_sig
);

   logic signed [XW-1:0] w_y;
   logic signed [XW-1:0] w_z;
   logic signed [XW-1:0] w_sum;
   logic signed [YW-1:0] w_sum_ext;
   logic signed [YW-1:0] w_sq;
   logic signed [YW-1:0] w_sh;

   // Magnitude folds the curve onto x >= 0; -128 wraps to itself.
   assign w_y       = i_x[XW-1] ? -i_x : i_x;
   assign w_z       = w_y >>> 2;
   assign w_sum     = w_z + SIG_BIAS;
   assign w_sum_ext = {{(YW-XW){w_sum[XW-1]}}, w_sum};
   assign w_sq      = w_sum_ext * w_sum_ext;
   assign w_sh      = w_sq >>> 1;
   assign o_sig     = i_x[XW-1] ? w_sh : (ONE_Q88 - w_sh);

endmodule : sig_pwq
`default_nettype wire

// File: rtl/sigmoid_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : sigmoid_rr_sched
// Brief   : Round-robin share of one sigmoid core among NREQ requesters,
//           2-stage pipeline with full-throughput backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module sigmoid_rr_sched
   import nn_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [XW*NREQ-1:0]   req_x,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [YW-1:0]        rsp_data,
   output logic [IDW-1:0]       rsp_id,
   input  logic                 rsp_ready
);

   localparam logic [IDW:0]   c_nreq = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] c_last = IDW'(NREQ-1);

   logic                 r_s1_vld;
   logic signed [XW-1:0] r_s1_x;
   logic [IDW-1:0]       r_s1_id;
   logic                 r_s2_vld;
   act_t                 r_s2_data;
   logic [IDW-1:0]       r_s2_id;
   logic [IDW-1:0]       r_rr_ptr;

   logic                 w_adv1;
   logic                 w_adv2;
   logic [2*NREQ-1:0]    w_dbl;
   logic [NREQ-1:0]      w_rot;
   logic                 w_any;
   logic [IDW-1:0]       w_pe;
   logic [IDW:0]         w_sum;
   logic [IDW-1:0]       w_gidx;
   logic [IDW-1:0]       w_next_ptr;
   logic [NREQ-1:0]      w_gnt;
   logic                 w_accept;
   act_t                 w_sig;

   assign w_adv2 = rsp_ready | ~r_s2_vld;
   assign w_adv1 = w_adv2 | ~r_s1_vld;

   // Rotate so the current pointer sits at bit 0, then pick the lowest set bit.
   assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
   assign w_rot = w_dbl[NREQ-1:0];

   always_comb begin
      w_any = 1'b0;
      w_pe  = '0;
      for (int j = NREQ-1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_any = 1'b1;
            w_pe  = IDW'(j);
         end
      end
   end

   assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_pe};
   assign w_gidx     = (w_sum >= c_nreq) ? w_sum[IDW-1:0] - c_nreq[IDW-1:0]
                                         : w_sum[IDW-1:0];
   assign w_next_ptr = (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
   assign w_gnt      = w_any ? (NREQ'(1) << w_gidx) : '0;
   assign w_accept   = w_any & w_adv1;

   // Gated with rst_n so ready drops the instant reset asserts.
   assign req_ready  = w_gnt & {NREQ{w_adv1 & rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_x   <= '0;
         r_s1_id  <= '0;
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_s1_vld <= 1'b1;
         r_s1_x   <= req_x[XW*w_gidx +: XW];
         r_s1_id  <= w_gidx;
         r_rr_ptr <= w_next_ptr;
      end else if (w_adv1) begin
         r_s1_vld <= 1'b0;
      end
   end

   sig_pwq u_sig (
      .i_x   (r_s1_x),
      .o_sig (w_sig)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld  <= 1'b0;
         r_s2_data <= '0;
         r_s2_id   <= '0;
      end else if (w_adv2) begin
         r_s2_vld  <= r_s1_vld;
         r_s2_data <= w_sig;
         r_s2_id   <= r_s1_id;
      end
   end

   assign rsp_valid = r_s2_vld;
   assign rsp_data  = r_s2_data;
   assign rsp_id    = r_s2_id;

endmodule : sigmoid_rr_sched
`default_nettype wire

// File: tb/tb_sigmoid_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sigmoid_rr_sched
// Brief   : Directed self-checking bench for the round-robin sigmoid scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sigmoid_rr_sched;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_x;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];

   sigmoid_rr_sched #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   // Reference sigmoid written with integer arithmetic.
   function automatic logic [15:0] golden(input int x);
      int y, z, s, sq, sh, r;
      if (x == -128)  y = -128;
      else if (x < 0) y = -x;
      else            y = x;
      if (y >= 0) z = y / 4;
      else        z = -((-y + 3) / 4);
      s = z - 16;
      if (s < -128) s += 256;
      if (s > 127)  s -= 256;
      sq = s * s;
      sh = sq / 2;
      r  = (x < 0) ? sh : 256 - sh;
      return r[15:0];
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b0;
      rsp_ready = 1'b1;
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      req_valid = 4'hF;
      req_x     = 32'h0;
      rsp_ready = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      checks += 4;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
      if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h expected 0000", rsp_data); end
      if (rsp_id !== 2'd0)    begin errors++; $display("FAIL reset_rsp_id got %0d expected 0", rsp_id); end
      if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
      do_reset();
   endtask

   task automatic test_single();
      logic [7:0]  xs [5] = '{8'd0, 8'd24, 8'hE8, 8'd64, 8'hC0};
      logic [15:0] ex [5] = '{16'd128, 16'd206, 16'd50, 16'd256, 16'd0};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         req_x[7:0] = xs[k];
         req_valid  = 4'b0001;
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready k=%0d got %b expected 0001", k, req_ready); end
         @(posedge clk); #1;
         req_valid = 4'b0;
         @(posedge clk); #1;
         checks += 3;
         if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid k=%0d got %b expected 1", k, rsp_valid); end
         if (rsp_data !== ex[k]) begin errors++; $display("FAIL single_data k=%0d got %0d expected %0d", k, rsp_data, ex[k]); end
         if (rsp_id !== 2'd0)    begin errors++; $display("FAIL single_id k=%0d got %0d expected 0", k, rsp_id); end
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop k=%0d got %b expected 0", k, rsp_valid); end
      end
   endtask

   task automatic test_all_valid();
      logic [1:0]  order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [15:0] exd   [4] = '{16'd158, 16'd8, 16'd216, 16'd1152};
      logic [3:0]  acc;
      exp_t        e;
      int          nacc = 0, nrsp = 0, last = -1;
      do_reset();
      req_x     = {8'h80, 8'd100, 8'hCE, 8'd10};
      req_valid = 4'hF;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL all_extra_rsp id=%0d data=%0d expected none", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_id !== e.id || rsp_data !== e.data) begin
                  errors++; $display("FAIL all_rsp got id=%0d data=%0d expected id=%0d data=%0d", rsp_id, rsp_data, e.id, e.data);
               end
            end
            if (last >= 0) begin
               checks++;
               if (cyc != last + 1) begin errors++; $display("FAIL all_gap got cycle %0d expected %0d", cyc, last + 1); end
            end
            last = cyc;
            nrsp++;
         end
         if (acc != 4'b0 && nacc < 5) begin
            checks++;
            if (acc !== (4'b0001 << order[nacc])) begin
               errors++; $display("FAIL all_grant n=%0d got %b expected id %0d", nacc, acc, order[nacc]);
            end
            sb.push_back('{id: order[nacc], data: exd[order[nacc]]});
            nacc++;
         end
         @(posedge clk); #1;
         if (nacc == 5) req_valid = 4'b0;
      end
      checks += 2;
      if (nacc != 5) begin errors++; $display("FAIL all_accepts got %0d expected 5", nacc); end
      if (nrsp != 5) begin errors++; $display("FAIL all_rsps got %0d expected 5", nrsp); end
   endtask

   task automatic test_stall();
      int          xv [4] = '{20, -8, 127, -100};
      logic [3:0]  acc;
      logic [15:0] hd;
      logic [1:0]  hid;
      exp_t        e;
      int          nacc = 0, nrsp = 0;
      logic [1:0]  g;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) req_x[8*i +: 8] = 8'(xv[i]);
      req_valid = 4'hF;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (cyc >= 3 && cyc <= 7) begin
            checks += 3;
            if (req_ready !== 4'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got %b expected 0000", cyc, req_ready); end
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b expected 1", cyc, rsp_valid); end
            if (sb.size() != 2)     begin errors++; $display("FAIL stall_buffered cyc=%0d got %0d expected 2", cyc, sb.size()); end
            if (cyc == 3) begin
               hd = rsp_data; hid = rsp_id;
            end else begin
               checks++;
               if (rsp_data !== hd || rsp_id !== hid) begin
                  errors++; $display("FAIL stall_hold cyc=%0d got id=%0d data=%0d expected id=%0d data=%0d", cyc, rsp_id, rsp_data, hid, hd);
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL stall_extra_rsp id=%0d data=%0d expected none", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_id !== e.id || rsp_data !== e.data) begin
                  errors++; $display("FAIL stall_rsp got id=%0d data=%0d expected id=%0d data=%0d", rsp_id, rsp_data, e.id, e.data);
               end
            end
            nrsp++;
         end
         if (acc != 4'b0) begin
            checks++;
            if (!$onehot(acc)) begin errors++; $display("FAIL stall_onehot got %b expected one-hot", acc); end
            g = idx_of(acc);
            sb.push_back('{id: g, data: golden(xv[g])});
            nacc++;
         end
         @(posedge clk); #1;
         if (cyc == 2) rsp_ready = 1'b0;
         if (cyc == 7) rsp_ready = 1'b1;
         if (nacc == 8) req_valid = 4'b0;
      end
      checks += 3;
      if (nacc != 8)      begin errors++; $display("FAIL stall_accepts got %0d expected 8", nacc); end
      if (nrsp != 8)      begin errors++; $display("FAIL stall_rsps got %0d expected 8", nrsp); end
      if (sb.size() != 0) begin errors++; $display("FAIL stall_leftover got %0d expected 0", sb.size()); end
   endtask

   task automatic test_sparse();
      logic [3:0] exg [3] = '{4'b1000, 4'b0010, 4'b1000};
      do_reset();
      req_x     = {8'd5, 8'd0, 8'd33, 8'd0};
      req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL sparse_prime got %b expected 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks += 2;
         if (req_ready !== exg[k]) begin errors++; $display("FAIL sparse_grant k=%0d got %b expected %b", k, req_ready, exg[k]); end
         if ((req_ready[0] | req_ready[2]) !== 1'b0) begin
            errors++; $display("FAIL sparse_invalid_idx k=%0d got %b expected bits 0,2 low", k, req_ready);
         end
         @(posedge clk); #1;
      end
      req_valid = 4'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      rsp_ready = 1'b1;
      req_x     = 32'h10203040;
      req_valid = 4'hF;
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b expected 1", rsp_valid); end
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b expected 0", rsp_valid); end
      if (req_ready !== 4'b0) begin errors++; $display("FAIL areset_ready got %b expected 0000", req_ready); end
      req_valid = 4'b0110;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks += 2;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL areset_first_grant got %b expected 0010", req_ready); end
      if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL areset_no_stale got %b expected 0", rsp_valid); end
      @(posedge clk); #1;
      req_valid = 4'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_sweep();
      logic [3:0] acc;
      exp_t       e;
      int         xi = -128, nacc = 0;
      do_reset();
      req_x[23:16] = 8'h80;
      req_valid    = 4'b0100;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL sweep_extra_rsp id=%0d data=%0d expected none", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_id !== e.id || rsp_data !== e.data) begin
                  errors++; $display("FAIL sweep_rsp got id=%0d data=%0d expected id=%0d data=%0d", rsp_id, rsp_data, e.id, e.data);
               end
            end
         end
         if (acc != 4'b0) begin
            checks++;
            if (acc !== 4'b0100) begin errors++; $display("FAIL sweep_grant got %b expected 0100", acc); end
            sb.push_back('{id: 2'd2, data: golden(xi)});
            nacc++;
         end
         @(posedge clk); #1;
         if (acc != 4'b0) begin
            xi++;
            if (nacc == 256) req_valid = 4'b0;
            else             req_x[23:16] = xi[7:0];
         end
      end
      checks += 2;
      if (nacc != 256)    begin errors++; $display("FAIL sweep_accepts got %0d expected 256", nacc); end
      if (sb.size() != 0) begin errors++; $display("FAIL sweep_leftover got %0d expected 0", sb.size()); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_all_valid();
      test_stall();
      test_sparse();
      test_async_reset();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sigmoid_rr_sched
`default_nettype wire
